alu_pipe: RTL and testbench

//  Responder side of the ALU operation interface: accepts {F,A,B} requests, returns {Y,Zero}.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_result_fifo.sv | 56 +++++
 rtl/alu_pipe.sv | 116 +++++++++++
 tb/tb_alu_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU pipe.
//   alu_op_t  - 3-bit op code carried on req_f
//   alu_res_t - {zero, y} evaluated at up to ALU_MAX_W bits
//   alu_eval  - combinational ALU evaluated at an arbitrary width w <= ALU_MAX_W
package alu_pkg;

    localparam int ALU_MAX_W = 64;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RSV  = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic                 zero;
        logic [ALU_MAX_W-1:0] y;
    } alu_res_t;

    // Operands arrive zero-extended to ALU_MAX_W; only the low w bits matter.
    function automatic alu_res_t alu_eval(input alu_op_t              op,
                                          input logic [ALU_MAX_W-1:0] a,
                                          input logic [ALU_MAX_W-1:0] b,
                                          input int                   w);
        logic [ALU_MAX_W-1:0]        mask;
        logic [ALU_MAX_W-1:0]        y;
        logic signed [ALU_MAX_W-1:0] a_s;
        logic signed [ALU_MAX_W-1:0] b_s;
        alu_res_t                    r;
        mask = (w >= ALU_MAX_W) ? '1 : ((ALU_MAX_W'(1) << w) - ALU_MAX_W'(1));
        // Left-justify so the w-bit sign bit lands in the MSB; ordering of the
        // signed values is preserved, so SLT never looks at a difference.
        a_s = $signed(a << (ALU_MAX_W - w));
        b_s = $signed(b << (ALU_MAX_W - w));
        unique case (op)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_ANDN: y = a & ~b;
            ALU_ORN:  y = a | ~b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = (a_s < b_s) ? ALU_MAX_W'(1) : '0;
            default:  y = '0;
        endcase
        y      = y & mask;
        r.y    = y;
        r.zero = ~|y;
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: in-order result buffer, DEPTH entries of WIDTH bits.
//   clk, rstn  - clock, async active-low reset (pointers/count only)
//   push, push_data - write an entry (caller guarantees space)
//   pop        - retire the head entry (caller guarantees non-empty)
//   head_data  - head entry, reads 0 while empty
//   count      - occupancy, 0..DEPTH
module alu_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with credit-limited in-order result FIFO.
//   clk, rstn                         - clock, async active-low reset
//   req_valid/req_ready, req_f/a/b    - request channel {op, A, B}
//   resp_valid/resp_ready, resp_y/zero - response channel {Y, Zero} from FIFO head
//   busy                              - S1 occupied or FIFO non-empty
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_f,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_zero,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_pipe: DEPTH must be a power of 2 and >= 2");
    end
    if (WIDTH < 1 || WIDTH > ALU_MAX_W) begin : g_bad_width
        $error("alu_pipe: WIDTH out of range");
    end

    logic                    s1_valid_q, s1_valid_d;
    alu_op_t                 s1_op_q, s1_op_d;
    logic signed [WIDTH-1:0] s1_a_q, s1_a_d;
    logic signed [WIDTH-1:0] s1_b_q, s1_b_d;

    logic          accept;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [WIDTH:0] head;
    alu_res_t      s1_res;
    logic [WIDTH:0] s1_entry;

    // ---- request acceptance -> S1 ----
    // Credit counts the in-flight S1 entry so the FIFO can never overflow;
    // no pop lookahead keeps req_ready free of any resp_ready path.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
        req_ready   = credit_used < (CW+1)'(DEPTH);
        accept      = req_valid & req_ready;
        s1_valid_d  = accept;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        if (accept) begin
            s1_op_d = alu_op_t'(req_f);
            s1_a_d  = req_a;
            s1_b_d  = req_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s1_valid_q <= 1'b0;
        else       s1_valid_q <= s1_valid_d;
    end

    always_ff @(posedge clk) begin
        s1_op_q <= s1_op_d;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
    end

    // ---- S1 evaluate -> FIFO push ----
    always_comb begin
        s1_res   = alu_eval(s1_op_q, ALU_MAX_W'($unsigned(s1_a_q)),
                            ALU_MAX_W'($unsigned(s1_b_q)), WIDTH);
        s1_entry = {s1_res.zero, s1_res.y[WIDTH-1:0]};
    end

    if (WIDTH < ALU_MAX_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^s1_res.y[ALU_MAX_W-1:WIDTH];
    end

    alu_result_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s1_valid_q),
        .push_data (s1_entry),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    // ---- FIFO head -> response ----
    assign resp_valid = fifo_count != '0;
    assign pop        = resp_valid & resp_ready;
    assign resp_y     = head[WIDTH-1:0];
    assign resp_zero  = head[WIDTH];
    assign busy       = s1_valid_q | (fifo_count != '0);

    property p_req_stable;
        @(posedge clk) disable iff (!rstn)
            (req_valid && !req_ready) |=>
                (req_valid && $stable(req_f) && $stable(req_a) && $stable(req_b));
    endproperty
    a_req_stable: assert property (p_req_stable)
        else $error("alu_pipe: request changed while stalled");

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_f;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_y;
    logic        resp_zero;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic [32:0] sb [$];

    alu_pipe #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_f      (req_f),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_zero  (resp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] y;
        case (f)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a + b;
            3'd4: y = a & ~b;
            3'd5: y = a | ~b;
            3'd6: y = a - b;
            3'd7: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: y = 32'd0;
        endcase
        return {(y == 32'd0), y};
    endfunction

    // Scoreboard: retire first (older entries), then record new accepts.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rstn) begin
            sb.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_y", 64'(resp_y), 64'(e[31:0]));
                    chk("sb_zero", 64'(resp_zero), 64'(e[32]));
                end
                n_pop++;
            end
            if (req_valid && req_ready) begin
                sb.push_back(ref_model(req_f, req_a, req_b));
                n_acc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
        bit done;
        req_f = f; req_a = a; req_b = b; req_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 100) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] y, output logic z);
        int k;
        k = 0;
        @(negedge clk);
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!resp_valid) chk("resp_timeout", 64'd1, 64'd0);
        y = resp_y;
        z = resp_zero;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int          st;
        int          stall_tot;
        int          cnt;
        int          acc0;
        int          pop0;
        int          k;
        bit          drv_done;
        logic [31:0] y;
        logic        z;

        rstn = 1'b0; req_valid = 1'b0; req_f = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_y", 64'(resp_y), 64'd0);
        chk("rst_resp_zero", 64'(resp_zero), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;

        // Two-edge latency on an empty pipe
        send(3'b010, 32'd2, 32'd3, st);
        @(negedge clk);
        chk("t1_latency_s1", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(resp_valid), 64'd1);
        chk("t1_y", 64'(resp_y), 64'd5);
        chk("t1_zero", 64'(resp_zero), 64'd0);
        @(posedge clk); #1;

        // Directed op corners
        send(3'b110, 32'd5, 32'd5, st);
        get_resp(y, z);
        chk("t2_sub_y", 64'(y), 64'd0);
        chk("t2_sub_zero", 64'(z), 64'd1);
        @(posedge clk); #1;
        send(3'b111, 32'hFFFF_FFFF, 32'd1, st);
        get_resp(y, z);
        chk("t2_slt_neg", 64'(y), 64'd1);
        @(posedge clk); #1;
        send(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, st);
        get_resp(y, z);
        chk("t2_slt_ovf", 64'(y), 64'd0);
        chk("t2_slt_ovf_zero", 64'(z), 64'd1);
        @(posedge clk); #1;

        // 16 back-to-back ops at full throughput
        stall_tot = 0;
        cnt = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(3'($urandom_range(0, 7)), $urandom, $urandom, st);
                    stall_tot += st;
                end
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (resp_valid) cnt++;
                end
            end
        join
        chk("t3_stalls", 64'(stall_tot), 64'd0);
        chk("t3_resp_count", 64'(cnt), 64'd16);
        wait_idle("t3_idle");
        @(posedge clk); #1;

        // Back-pressure: credit admits exactly DEPTH requests
        resp_ready = 1'b0;
        acc0 = n_acc;
        pop0 = n_pop;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(3'($urandom_range(0, 7)), $urandom, $urandom, st);
                end
                drv_done = 1'b1;
            end
        join_none
        repeat (8) @(negedge clk);
        chk("t4_accepts", 64'(n_acc - acc0), 64'd4);
        chk("t4_req_ready_low", 64'(req_ready), 64'd0);
        chk("t4_resp_valid", 64'(resp_valid), 64'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_lookahead", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("t4_ready_back", 64'(req_ready), 64'd1);
        k = 0;
        while (!drv_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_driver_done", 64'(drv_done), 64'd1);
        wait_idle("t4_idle");
        chk("t4_pops", 64'(n_pop - pop0), 64'd6);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Full credit with S1 pending: push and pop on the same edge
        resp_ready = 1'b0;
        pop0 = n_pop;
        for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom, st);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t5_credit_full", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("t5_after_pushpop_ready", 64'(req_ready), 64'd1);
        chk("t5_after_pushpop_valid", 64'(resp_valid), 64'd1);
        wait_idle("t5_idle");
        chk("t5_pops", 64'(n_pop - pop0), 64'd4);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Async reset mid-flight discards S1 and FIFO
        resp_ready = 1'b0;
        send(3'b001, 32'h1, 32'h2, st);
        send(3'b010, 32'h3, 32'h4, st);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_resp_valid_async", 64'(resp_valid), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_req_ready_async", 64'(req_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        resp_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("t6_no_stale", 64'(cnt), 64'd0);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
